// File: rtl/apb4_user_ip_mux.sv
// APB4 fan-out to NUM_CH user-IP channels. Zero-latency combinational path for
// valid channels. Bad selects and hung slaves complete with PSLVERR instead of stalling.
module apb4_user_ip_mux #(
  parameter int NUM_CH      = 4,
  parameter int SEL_WIDTH   = 5,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [SEL_WIDTH-1:0]                 sel_i,
  input  logic [ADDR_WIDTH-1:0]                s_paddr,
  input  logic [2:0]                           s_pprot,
  input  logic                                 s_psel,
  input  logic                                 s_penable,
  input  logic                                 s_pwrite,
  input  logic [DATA_WIDTH-1:0]                s_pwdata,
  input  logic [DATA_WIDTH/8-1:0]              s_pstrb,
  output logic                                 s_pready,
  output logic [DATA_WIDTH-1:0]                s_prdata,
  output logic                                 s_pslverr,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    m_paddr,
  output logic [NUM_CH-1:0][2:0]               m_pprot,
  output logic [NUM_CH-1:0]                    m_psel,
  output logic [NUM_CH-1:0]                    m_penable,
  output logic [NUM_CH-1:0]                    m_pwrite,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]    m_pwdata,
  output logic [NUM_CH-1:0][DATA_WIDTH/8-1:0]  m_pstrb,
  input  logic [NUM_CH-1:0]                    m_pready,
  input  logic [NUM_CH-1:0]                    m_pslverr,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    m_prdata,
  output logic [SEL_WIDTH-1:0]                 act_sel_o,
  output logic [CNT_WIDTH-1:0]                 timeout_cnt_o,
  output logic [CNT_WIDTH-1:0]                 decerr_cnt_o,
  output logic                                 err_pulse_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ABORT} state_e;

  localparam int WAIT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_e                 state_q, state_d, phase;
  logic [SEL_WIDTH-1:0]   act_sel_q, act_sel_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [CNT_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d, dec_cnt_q, dec_cnt_d;
  logic                   err_pulse_q, err_pulse_d;

  logic [NUM_CH-1:0]      sel_oh;
  logic                   sel_valid;
  logic                   sel_pready, sel_pslverr;
  logic [DATA_WIDTH-1:0]  sel_prdata;
  logic                   dec_cpl, tmo_cpl;

  // One-hot decode by loop so an out-of-range select never indexes the arrays.
  always_comb begin
    sel_oh      = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (32'(act_sel_q) == 32'(ch)) begin
        sel_oh[ch]  = 1'b1;
        sel_pready  = m_pready[ch];
        sel_pslverr = m_pslverr[ch];
        sel_prdata  = m_prdata[ch];
      end
    end
    sel_valid = |sel_oh;
  end

  always_comb begin
    m_paddr   = '0;
    m_pprot   = '0;
    m_psel    = '0;
    m_penable = '0;
    m_pwrite  = '0;
    m_pwdata  = '0;
    m_pstrb   = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (sel_oh[ch] && s_psel && (state_q != ABORT)) begin
        m_psel[ch]    = 1'b1;
        m_penable[ch] = s_penable;
        m_paddr[ch]   = s_paddr;
        m_pprot[ch]   = s_pprot;
        m_pwrite[ch]  = s_pwrite;
        m_pwdata[ch]  = s_pwdata;
        m_pstrb[ch]   = s_pstrb;
      end
    end
  end

  always_comb begin
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    s_prdata  = '0;
    case (state_q)
      ACCESS: begin
        if (sel_valid) begin
          s_pready  = sel_pready;
          s_pslverr = sel_pslverr;
          s_prdata  = sel_prdata;
        end else begin
          s_pready  = 1'b1;
          s_pslverr = 1'b1;
        end
      end
      ABORT: begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
      end
      default: ;
    endcase
  end

  // SETUP is the idle cycle in which the master presents psel without penable.
  always_comb begin
    phase = state_q;
    if ((state_q == IDLE) && s_psel && !s_penable) phase = SETUP;
    state_d = phase;
    case (phase)
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (s_pready || !s_psel)
          state_d = IDLE;
        else if ((TIMEOUT_CYC != 0) && (wait_q == WAIT_LAST))
          state_d = ABORT;
      end
      ABORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wait_d    = ((state_q == ACCESS) && (state_d == ACCESS)) ? wait_q + 1'b1 : '0;
    act_sel_d = s_psel ? act_sel_q : sel_i;

    dec_cpl     = (state_q == ACCESS) && !sel_valid;
    tmo_cpl     = (state_q == ABORT);
    err_pulse_d = dec_cpl || tmo_cpl;
    dec_cnt_d   = (dec_cpl && (dec_cnt_q != '1)) ? dec_cnt_q + 1'b1 : dec_cnt_q;
    tmo_cnt_d   = (tmo_cpl && (tmo_cnt_q != '1)) ? tmo_cnt_q + 1'b1 : tmo_cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      act_sel_q   <= '0;
      wait_q      <= '0;
      tmo_cnt_q   <= '0;
      dec_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_sel_q   <= act_sel_d;
      wait_q      <= wait_d;
      tmo_cnt_q   <= tmo_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign act_sel_o     = act_sel_q;
  assign timeout_cnt_o = tmo_cnt_q;
  assign decerr_cnt_o  = dec_cnt_q;
  assign err_pulse_o   = err_pulse_q;

endmodule

// File: tb/tb_apb4_user_ip_mux.sv
// Directed bench for apb4_user_ip_mux: APB master task pushes expectations,
// a negedge monitor pops them on every upstream completion.
module tb_apb4_user_ip_mux;
  localparam int NCH = 4;
  localparam int SW  = 5;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [SW-1:0]            sel_i;
  logic [31:0]              s_paddr, s_pwdata, s_prdata;
  logic [2:0]               s_pprot;
  logic                     s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [3:0]               s_pstrb;
  logic [NCH-1:0][31:0]     m_paddr, m_pwdata, m_prdata;
  logic [NCH-1:0][2:0]      m_pprot;
  logic [NCH-1:0][3:0]      m_pstrb;
  logic [NCH-1:0]           m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [SW-1:0]            act_sel_o;
  logic [7:0]               timeout_cnt_o, decerr_cnt_o;
  logic                     err_pulse_o;

  apb4_user_ip_mux #(.NUM_CH(NCH), .SEL_WIDTH(SW), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                     .TIMEOUT_CYC(16), .CNT_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i),
    .s_paddr(s_paddr), .s_pprot(s_pprot), .s_psel(s_psel), .s_penable(s_penable),
    .s_pwrite(s_pwrite), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_pprot(m_pprot), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
    .act_sel_o(act_sel_o), .timeout_cnt_o(timeout_cnt_o),
    .decerr_cnt_o(decerr_cnt_o), .err_pulse_o(err_pulse_o));

  always #5 clk_i = ~clk_i;

  // Simple slave models: programmable wait states, hang and error flags.
  int         wcfg [NCH];
  int         wcnt [NCH];
  logic [NCH-1:0] hang, errcfg;

  always @(posedge clk_i or posedge rst_i) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (rst_i) wcnt[ch] <= 0;
      else if (m_psel[ch] && m_penable[ch] && !m_pready[ch]) wcnt[ch] <= wcnt[ch] + 1;
      else wcnt[ch] <= 0;
    end
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      m_pready[ch]  = m_psel[ch] && m_penable[ch] && !hang[ch] && (wcnt[ch] >= wcfg[ch]);
      m_pslverr[ch] = errcfg[ch];
      m_prdata[ch]  = 32'(ch + 1) * 32'h1111_1111;
    end
  end

  typedef struct {
    logic                 rd;
    logic [31:0]          rdata;
    logic                 err;
    logic [NCH-1:0]       psel;
    logic [NCH-1:0][31:0] wdata;
    logic [NCH-1:0][31:0] addr;
    int                   cyc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ch < 0 means no downstream channel is expected to be selected.
  task automatic push(input logic rd, input int ch, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rdata, input logic err, input int cyc);
    exp_t e;
    e.rd = rd; e.rdata = rdata; e.err = err; e.cyc = cyc;
    e.psel = '0; e.wdata = '0; e.addr = '0;
    if (ch >= 0) begin
      e.psel[ch]  = 1'b1;
      e.wdata[ch] = wd;
      e.addr[ch]  = addr;
    end
    sbq.push_back(e);
  endtask

  int mon_cyc = 0;
  int mon_start = 0;
  always @(negedge clk_i) begin : monitor
    exp_t e;
    mon_cyc++;
    if (!rst_i && s_psel && !s_penable) mon_start = mon_cyc;
    if (!rst_i && s_psel && s_penable && s_pready) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_completion: got a completion, expected none");
      end else begin
        e = sbq.pop_front();
        chk("cpl_pslverr", s_pslverr, e.err);
        chk("cpl_m_psel", m_psel, e.psel);
        chk("cpl_m_pwdata", m_pwdata, e.wdata);
        chk("cpl_m_paddr", m_paddr, e.addr);
        chk("cpl_cycles", 128'(mon_cyc - mon_start + 1), 128'(e.cyc));
        if (e.rd) chk("cpl_prdata", s_prdata, e.rdata);
      end
    end
  end

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    @(posedge clk_i); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr; s_paddr = addr; s_pwdata = wd;
    s_pstrb = wr ? 4'hF : 4'h0; s_pprot = 3'b000;
    @(posedge clk_i); #1;
    s_penable = 1'b1;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (s_pready) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL apb_wait_bound: got no PREADY after %0d cycles, expected completion", n);
        break;
      end
    end
    @(posedge clk_i); #1;
    s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
    s_paddr = '0; s_pwdata = '0; s_pstrb = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; sel_i = '0;
    s_paddr = '0; s_pprot = '0; s_psel = 1'b0; s_penable = 1'b0;
    s_pwrite = 1'b0; s_pwdata = '0; s_pstrb = '0;
    hang = '0; errcfg = '0;
    for (int ch = 0; ch < NCH; ch++) wcfg[ch] = 0;
    repeat (3) @(posedge clk_i); #1;
    chk("rst_pready", s_pready, 1'b0);
    chk("rst_m_psel", m_psel, '0);
    chk("rst_act_sel", act_sel_o, '0);
    chk("rst_decerr", decerr_cnt_o, '0);
    chk("rst_timeout", timeout_cnt_o, '0);
    chk("rst_err_pulse", err_pulse_o, 1'b0);
    @(negedge clk_i); rst_i = 1'b0;

    // Zero-wait write to channel 2.
    sel_i = 5'd2;
    push(1'b0, 2, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    apb(1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("wr_act_sel", act_sel_o, 5'd2);
    chk("wr_no_err_pulse", err_pulse_o, 1'b0);

    // Decode error on an unpopulated select.
    sel_i = 5'd5;
    push(1'b1, -1, 32'h20, 32'h0, 32'h0, 1'b1, 2);
    apb(1'b0, 32'h20, 32'h0);
    chk("dec_cnt", decerr_cnt_o, 8'd1);
    chk("dec_pulse_hi", err_pulse_o, 1'b1);
    @(posedge clk_i); #1;
    chk("dec_pulse_lo", err_pulse_o, 1'b0);

    // Slave-reported error passes through but is not counted here.
    sel_i = 5'd3; errcfg[3] = 1'b1;
    push(1'b0, 3, 32'h44, 32'h1234_5678, 32'h0, 1'b1, 2);
    apb(1'b1, 32'h44, 32'h1234_5678);
    chk("slverr_no_pulse", err_pulse_o, 1'b0);
    chk("slverr_dec_cnt", decerr_cnt_o, 8'd1);
    errcfg[3] = 1'b0;

    // Hung channel 1: 16 wait cycles then an ABORT completion.
    sel_i = 5'd1; hang[1] = 1'b1;
    push(1'b1, -1, 32'h30, 32'h0, 32'h0, 1'b1, 18);
    apb(1'b0, 32'h30, 32'h0);
    chk("tmo_cnt", timeout_cnt_o, 8'd1);
    chk("tmo_pulse", err_pulse_o, 1'b1);
    hang[1] = 1'b0;
    push(1'b1, 1, 32'h34, 32'h0, 32'h2222_2222, 1'b0, 2);
    apb(1'b0, 32'h34, 32'h0);
    chk("tmo_recover_cnt", timeout_cnt_o, 8'd1);

    // Select change mid-transfer: read still served by channel 1.
    wcfg[1] = 3;
    push(1'b1, 1, 32'h38, 32'h0, 32'h2222_2222, 1'b0, 5);
    fork
      apb(1'b0, 32'h38, 32'h0);
      begin repeat (2) @(posedge clk_i); #2; sel_i = 5'd3; end
    join
    chk("toggle_act_sel_hold", act_sel_o, 5'd1);
    @(posedge clk_i); #1;
    chk("toggle_act_sel_new", act_sel_o, 5'd3);
    wcfg[1] = 0;

    // Decode-error counter saturation.
    sel_i = 5'd5;
    for (int i = 0; i < 300; i++) begin
      push(1'b1, -1, 32'h50, 32'h0, 32'h0, 1'b1, 2);
      apb(1'b0, 32'h50, 32'h0);
      chk("sat_pulse", err_pulse_o, 1'b1);
      if (i == 99) chk("sat_cnt_mid", decerr_cnt_o, 8'd101);
    end
    chk("sat_cnt", decerr_cnt_o, 8'd255);

    // Asynchronous reset during a wait state on channel 2.
    sel_i = 5'd2; wcfg[2] = 10;
    @(posedge clk_i); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h60;
    @(posedge clk_i); #1;
    s_penable = 1'b1;
    repeat (3) @(posedge clk_i);
    #3;
    rst_i = 1'b1; s_psel = 1'b0; s_penable = 1'b0; s_paddr = '0;
    #1;
    chk("arst_pready", s_pready, 1'b0);
    chk("arst_pslverr", s_pslverr, 1'b0);
    chk("arst_m_psel", m_psel, '0);
    chk("arst_m_penable", m_penable, '0);
    chk("arst_act_sel", act_sel_o, '0);
    chk("arst_decerr", decerr_cnt_o, '0);
    chk("arst_timeout", timeout_cnt_o, '0);
    chk("arst_pulse", err_pulse_o, 1'b0);
    sel_i = 5'd3; wcfg[2] = 0;
    @(negedge clk_i); rst_i = 1'b0;
    #1;
    chk("post_rst_act_sel", act_sel_o, '0);
    @(posedge clk_i); #1;
    chk("post_rst_load", act_sel_o, 5'd3);
    push(1'b1, 3, 32'h70, 32'h0, 32'h4444_4444, 1'b0, 2);
    apb(1'b0, 32'h70, 32'h0);

    repeat (2) @(posedge clk_i);
    chk("sb_empty", 128'(sbq.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
